// File: rtl/syncnt_mod.sv
// -----------------------------------------------------------------------------
// syncnt_mod
//
// Parametrised synchronous up/down counter with programmable modulus, parallel
// load and a cascade-ready terminal-count output. The count range is
// 0 .. MODULUS-1 and all state changes happen on the rising edge of clk.
//
// Next-state priority at each edge: rst > load > en > hold.
//
// Optional feature macro: SYNCNT_MOD_SAT_EN
//   When it is defined, a sat input is added. With sat=1, an enabled count at
//   the boundary in the current direction holds q and still pulses ovf.
//   When it is undefined, there is no sat port and the counter always wraps.
//
// Parameters:
//   WIDTH    counter width in bits (>= 1)
//   MODULUS  count modulus, 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   clk   in   1      clock, rising edge
//   rst   in   1      synchronous active-high reset
//   en    in   1      count enable
//   down  in   1      direction, 0 = up, 1 = down
//   load  in   1      parallel load strobe (load value is clamped to MODULUS-1)
//   d     in   WIDTH  load value
//   sat   in   1      saturate-mode select (only with SYNCNT_MOD_SAT_EN)
//   q     out  WIDTH  current count
//   tc    out  1      terminal count, combinational; drives en of next stage
//   ovf   out  1      registered one-cycle wrap/saturation pulse
// -----------------------------------------------------------------------------
module syncnt_mod #(
  parameter int                WIDTH   = 8,
  parameter longint unsigned   MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`ifdef SYNCNT_MOD_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  // Reject parameter combinations outside the supported range at elaboration.
  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_param
    $error("syncnt_mod: illegal WIDTH/MODULUS combination");
  end

  // Top of the count range, held in WIDTH bits so that MODULUS = 2**WIDTH
  // needs no extra compare bit.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic at_zero;
  logic at_max;
  logic at_bound;

  assign at_zero  = (count_q == '0);
  assign at_max   = (count_q == MAX_VAL);
  // Boundary in the currently selected direction; tc follows down in the
  // same cycle and never depends on d.
  assign at_bound = down ? at_zero : at_max;

  assign tc  = en & ~load & at_bound;
  assign q   = count_q;
  assign ovf = ovf_q;

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (load) begin
      // ">=" rather than ">" keeps the compare meaningful when MAX_VAL is
      // all ones; the result is identical.
      count_d = (d >= MAX_VAL) ? MAX_VAL : d;
    end else if (en) begin
      if (down) begin
        ovf_d   = at_zero;
        count_d = at_zero ? MAX_VAL : (count_q - ONE);
      end else begin
        // Out-of-range values (only reachable by upset) wrap to 0 as well.
        ovf_d   = (count_q >= MAX_VAL);
        count_d = (count_q >= MAX_VAL) ? '0 : (count_q + ONE);
      end
`ifdef SYNCNT_MOD_SAT_EN
      // Saturation: hold at the boundary, ovf still pulses.
      if (sat && at_bound) begin
        count_d = count_q;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
